// File: rtl/random_gen16_pkg.sv
// random_gen16_pkg
//   Shared constants and the LFSR next-state function for the 16-bit
//   pseudo-random source. Golden models may reuse lfsr_next.
package random_gen16_pkg;

    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] DEFAULT_TAPS      = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_ZERO_SEED = 16'hACE1;

    // One Fibonacci step: the parity of the tapped bits enters bit 0
    // while the register shifts left.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] taps
    );
        return {s[LFSR_W-2:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/random_gen16.sv
// random_gen16
//   Free-running maximal-length Fibonacci LFSR producing one new 16-bit
//   pseudo-random value per clock. Loaded from seed while reset is held.
// Ports
//   clk    in   1   clock, all state changes on posedge
//   rst_n  in   1   synchronous reset, ACTIVE-HIGH despite the name
//   seed   in   16  state loaded on reset edges (0 maps to ZERO_SEED)
//   data   out 16  current LFSR state, straight from the flops
module random_gen16
    import random_gen16_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS      = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] ZERO_SEED = DEFAULT_ZERO_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] data
);

    // An all-zero seed would lock the LFSR; a missing top tap would make
    // the register shorter than 16 bits and break the period.
    if (ZERO_SEED == '0) begin : g_bad_zero_seed
        $fatal(1, "random_gen16: ZERO_SEED must be nonzero");
    end
    if (TAPS[LFSR_W-1] == 1'b0) begin : g_bad_taps
        $fatal(1, "random_gen16: TAPS[15] must be set");
    end

    logic [LFSR_W-1:0] state;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= (seed != '0) ? seed : ZERO_SEED;
        end else begin
            state <= lfsr_next(state, TAPS);
        end
    end

    assign data = state;

    // Once loaded with a nonzero value the state can never reach zero.
    a_never_zero : assert property (
        @(posedge clk) disable iff (rst_n) (state != '0)
    ) else $error("random_gen16: LFSR state reached zero");

endmodule

// File: tb/tb_random_gen16.sv
module tb_random_gen16;

    logic        clk;
    logic        rst_n;
    logic [15:0] seed;
    logic [15:0] data;

    int checks = 0;
    int errors = 0;

    random_gen16 #(
        .TAPS      (16'hB400),
        .ZERO_SEED (16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (seed),
        .data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: taps at bit positions 15,13,12,10; the new low
    // bit is the count of set tapped bits modulo 2, the rest is s*2 mod 2^16.
    function automatic int model_step(input int s);
        int ones;
        ones = 0;
        if ((s / 32768) % 2 == 1) ones++;
        if ((s / 8192)  % 2 == 1) ones++;
        if ((s / 4096)  % 2 == 1) ones++;
        if ((s / 1024)  % 2 == 1) ones++;
        return ((s * 2) % 65536) + (ones % 2);
    endfunction

    int model_state = 0;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            model_state = (seed == 16'h0) ? 'hACE1 : int'(seed);
            model_valid = 1'b1;
        end else if (model_valid) begin
            model_state = model_step(model_state);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (data !== 16'(model_state)) begin
                errors++;
                $display("FAIL model_cmp t=%0t data=%h expected=%h", $time, data, 16'(model_state));
            end
        end
    end

    task automatic check_now(input logic [15:0] exp, input string name);
        checks++;
        if (data !== exp) begin
            errors++;
            $display("FAIL %s data=%0d (%h) expected=%0d (%h)", name, data, data, exp, exp);
        end
    endtask

    // Sample one edge later, away from the edge itself.
    task automatic edge_check(input logic [15:0] exp, input string name);
        @(posedge clk);
        #1;
        check_now(exp, name);
    endtask

    task automatic do_reset(input logic [15:0] s, input int unsigned edges);
        @(negedge clk);
        rst_n = 1'b1;
        seed  = s;
        repeat (edges) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    int first_one;
    int zero_seen;

    initial begin
        rst_n = 1'b1;
        seed  = 16'd123;

        // Directed sequence from seed 123 with one reset edge.
        edge_check(16'd123, "seed123_reset");
        @(negedge clk);
        rst_n = 1'b0;
        edge_check(16'd246,  "seed123_s1");
        edge_check(16'd492,  "seed123_s2");
        edge_check(16'd984,  "seed123_s3");
        edge_check(16'd1968, "seed123_s4");
        edge_check(16'd3937, "seed123_s5");

        // seed changes while running are ignored (model keeps stepping).
        @(negedge clk);
        seed = 16'h1234;
        repeat (20) @(posedge clk);

        // Reset held 3 edges mid-run: every reset edge shows the seed.
        @(negedge clk);
        seed  = 16'd123;
        rst_n = 1'b1;
        edge_check(16'd123, "rst3_e1");
        edge_check(16'd123, "rst3_e2");
        edge_check(16'd123, "rst3_e3");
        @(negedge clk);
        rst_n = 1'b0;
        edge_check(16'd246, "replay_s1");
        edge_check(16'd492, "replay_s2");
        edge_check(16'd984, "replay_s3");

        // Zero seed maps to ZERO_SEED.
        @(negedge clk);
        seed  = 16'h0000;
        rst_n = 1'b1;
        edge_check(16'hACE1, "zero_seed_reset");
        @(negedge clk);
        rst_n = 1'b0;
        edge_check(16'h59C3, "zero_seed_s1");
        repeat (30) @(posedge clk);

        // Full period from seed 1.
        do_reset(16'h0001, 1);
        first_one = 0;
        zero_seen = 0;
        for (int i = 1; i <= 65535; i++) begin
            @(posedge clk);
            #1;
            if (data == 16'h0) zero_seen++;
            if (data == 16'h1 && first_one == 0) first_one = i;
        end
        checks++;
        if (first_one != 65535) begin
            errors++;
            $display("FAIL period first_return=%0d expected=65535", first_one);
        end
        checks++;
        if (zero_seen != 0) begin
            errors++;
            $display("FAIL never_zero zero_count=%0d expected=0", zero_seen);
        end

        // Random seeds, each checked by the model for several steps.
        for (int n = 0; n < 1000; n++) begin
            do_reset(16'($urandom_range(0, 65535)), 1);
            repeat (8) @(posedge clk);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
